// File: rtl/wb_store_buffer_if.sv
// wb_store_buffer_if: writeback store, dcache write and load-hazard signals of the store buffer
interface wb_store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic                       v_wb_store;
  logic [ADDR_W-1:0]          wb_store_addr;
  logic [DATA_W-1:0]          wb_store_data;
  logic [DATA_W/8-1:0]        wb_store_mask;
  logic                       sb_full;
  logic                       sb_empty;
  logic [$clog2(DEPTH):0]     sb_count;
  logic                       dc_wr_req;
  logic [ADDR_W-1:0]          dc_wr_addr;
  logic [DATA_W-1:0]          dc_wr_data;
  logic [DATA_W/8-1:0]        dc_wr_mask;
  logic                       dc_wr_ack;
  logic                       ld_check_v;
  logic [ADDR_W-1:0]          ld_check_addr;
  logic                       sb_ld_hit;
  modport master (
    output v_wb_store, wb_store_addr, wb_store_data, wb_store_mask, dc_wr_ack, ld_check_v, ld_check_addr,
    input  sb_full, sb_empty, sb_count, dc_wr_req, dc_wr_addr, dc_wr_data, dc_wr_mask, sb_ld_hit
  );
  modport slave (
    input  v_wb_store, wb_store_addr, wb_store_data, wb_store_mask, dc_wr_ack, ld_check_v, ld_check_addr,
    output sb_full, sb_empty, sb_count, dc_wr_req, dc_wr_addr, dc_wr_data, dc_wr_mask, sb_ld_hit
  );
endinterface

// File: rtl/wb_store_buffer.sv
// wb_store_buffer: in-order store FIFO draining to the dcache, with load-hazard lookup; SB_COALESCE_EN enables line merging into the youngest entry
module wb_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input logic                CLK,
  input logic                CLR,
  wb_store_buffer_if.slave   sb
);
  localparam int MW  = DATA_W / 8;
  localparam int OFF = $clog2(MW);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [MW-1:0]     mask_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;
  logic              full, alloc, deq, hit, merge_hit;
  assign full  = count_q == CW'(DEPTH);
  assign deq   = sb.dc_wr_req && sb.dc_wr_ack;
  assign alloc = sb.v_wb_store && !full && !merge_hit;
  assign sb.sb_empty   = count_q == '0;
  assign sb.sb_count   = count_q;
  assign sb.dc_wr_req  = !sb.sb_empty;
  assign sb.dc_wr_addr = addr_q[head_q];
  assign sb.dc_wr_data = data_q[head_q];
  assign sb.dc_wr_mask = mask_q[head_q];
`ifdef SB_COALESCE_EN
  logic [PW-1:0]     yng;
  logic [DATA_W-1:0] merged_d;
  assign yng       = tail_q - 1'b1;
  assign merge_hit = sb.v_wb_store && count_q >= CW'(2) &&
                     addr_q[yng][ADDR_W-1:OFF] == sb.wb_store_addr[ADDR_W-1:OFF];
  assign sb.sb_full = full && !merge_hit;
  // byte-wise overlay of the incoming store onto the youngest entry
  always_comb begin
    merged_d = data_q[yng];
    for (int b = 0; b < MW; b++)
      merged_d[8*b +: 8] = sb.wb_store_mask[b] ? sb.wb_store_data[8*b +: 8] : data_q[yng][8*b +: 8];
  end
`else
  assign merge_hit  = 1'b0;
  assign sb.sb_full = full;
`endif
  // load overlaps any registered valid entry on the same line; stores arriving this cycle are not seen
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (vld_q[i] && addr_q[i][ADDR_W-1:OFF] == sb.ld_check_addr[ADDR_W-1:OFF]);
    sb.sb_ld_hit = sb.ld_check_v && hit;
  end
  // FIFO state: allocate at tail, retire head on ack, optional merge into youngest entry
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc) begin
        addr_q[tail_q] <= sb.wb_store_addr;
        data_q[tail_q] <= sb.wb_store_data;
        mask_q[tail_q] <= sb.wb_store_mask;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + 1'b1;
      end
`ifdef SB_COALESCE_EN
      if (merge_hit) begin
        data_q[yng] <= merged_d;
        mask_q[yng] <= mask_q[yng] | sb.wb_store_mask;
      end
`endif
      if (deq) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(alloc) - CW'(deq);
    end
  end
endmodule

// File: tb/tb_wb_store_buffer.sv
// tb_wb_store_buffer: directed self-checking bench for wb_store_buffer (honours SB_COALESCE_EN)
module tb_wb_store_buffer;
  logic CLK = 1'b0;
  logic CLR = 1'b1;
  int   total = 0;
  int   fails = 0;
  wb_store_buffer_if #(.DEPTH(4), .ADDR_W(32), .DATA_W(64)) bus ();
  wb_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(64)) dut (.CLK(CLK), .CLR(CLR), .sb(bus.slave));
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic put(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    bus.v_wb_store    = 1'b1;
    bus.wb_store_addr = a;
    bus.wb_store_data = d;
    bus.wb_store_mask = m;
  endtask
  initial begin
    bus.v_wb_store = 0; bus.wb_store_addr = 0; bus.wb_store_data = 0; bus.wb_store_mask = 0;
    bus.dc_wr_ack = 0; bus.ld_check_v = 0; bus.ld_check_addr = 0;
    #12;
    chk("rst_count", bus.sb_count, 0);
    chk("rst_empty", bus.sb_empty, 1);
    chk("rst_full", bus.sb_full, 0);
    chk("rst_req", bus.dc_wr_req, 0);
    chk("rst_hit", bus.sb_ld_hit, 0);
    chk("rst_addr", bus.dc_wr_addr, 0);
    chk("rst_data", bus.dc_wr_data, 0);
    chk("rst_mask", bus.dc_wr_mask, 0);
    tick();
    CLR = 0;
    tick();
    // single store, ack tied high
    bus.dc_wr_ack = 1;
    put(32'h1008, 64'h11223344_55667788, 8'hFF);
    #1 chk("single_no_bypass", bus.dc_wr_req, 0);
    tick();
    bus.v_wb_store = 0;
    chk("single_req", bus.dc_wr_req, 1);
    chk("single_addr", bus.dc_wr_addr, 32'h1008);
    chk("single_data", bus.dc_wr_data, 64'h11223344_55667788);
    chk("single_mask", bus.dc_wr_mask, 8'hFF);
    tick();
    chk("single_empty", bus.sb_empty, 1);
    chk("single_req_off", bus.dc_wr_req, 0);
    // fill and stall
    bus.dc_wr_ack = 0;
    for (int i = 0; i < 5; i++) begin
      put(32'h100 + 32'(8*i), 64'(i), 8'hFF);
      tick();
    end
    chk("fill_count", bus.sb_count, 4);
    chk("fill_full", bus.sb_full, 1);
    chk("fill_head", bus.dc_wr_addr, 32'h100);
    bus.dc_wr_ack = 1;
    tick();
    chk("fill_ack_count", bus.sb_count, 3);
    chk("fill_ack_full", bus.sb_full, 0);
    chk("fill_ack_head", bus.dc_wr_addr, 32'h108);
    bus.dc_wr_ack = 0;
    tick();
    bus.v_wb_store = 0;
    chk("fill_fifth_count", bus.sb_count, 4);
    bus.dc_wr_ack = 1;
    for (int i = 1; i < 5; i++) begin
      chk("fill_drain_addr", bus.dc_wr_addr, 32'h100 + 32'(8*i));
      chk("fill_drain_data", bus.dc_wr_data, 64'(i));
      tick();
    end
    chk("fill_drained", bus.sb_empty, 1);
    // streaming with wrap-around, count held at 1
    for (int i = 0; i < 10; i++) begin
      put(32'h400 + 32'(8*i), 64'(100 + i), 8'h0F);
      if (i > 0) begin
        chk("wrap_addr", bus.dc_wr_addr, 32'h400 + 32'(8*(i-1)));
        chk("wrap_count", bus.sb_count, 1);
      end
      tick();
    end
    bus.v_wb_store = 0;
    chk("wrap_last", bus.dc_wr_addr, 32'h448);
    tick();
    chk("wrap_empty", bus.sb_empty, 1);
    // load hazard
    bus.dc_wr_ack = 0;
    put(32'h2000, 64'h1, 8'hFF);
    tick();
    put(32'h2010, 64'h2, 8'hFF);
    tick();
    bus.v_wb_store = 0;
    bus.ld_check_v = 1; bus.ld_check_addr = 32'h2004;
    #1 chk("hz_hit_2004", bus.sb_ld_hit, 1);
    bus.ld_check_addr = 32'h2008;
    #1 chk("hz_miss_2008", bus.sb_ld_hit, 0);
    bus.ld_check_addr = 32'h2014;
    #1 chk("hz_hit_2014", bus.sb_ld_hit, 1);
    bus.ld_check_v = 0; bus.ld_check_addr = 32'h2004;
    #1 chk("hz_v_low", bus.sb_ld_hit, 0);
    bus.ld_check_v = 1; bus.ld_check_addr = 32'h3000;
    put(32'h3000, 64'h3, 8'hFF);
    #1 chk("hz_enq_not_seen", bus.sb_ld_hit, 0);
    bus.v_wb_store = 0;
    bus.dc_wr_ack = 1; bus.ld_check_addr = 32'h2000;
    #1 chk("hz_acked_hits", bus.sb_ld_hit, 1);
    tick();
    #1 chk("hz_after_ack", bus.sb_ld_hit, 0);
    tick();
    bus.ld_check_v = 0;
    chk("hz_empty", bus.sb_empty, 1);
    // coalescing
    bus.dc_wr_ack = 0;
    put(32'h300, 64'h01020304_05060708, 8'h0F);
    tick();
    put(32'h340, 64'h11111111_11111111, 8'h01);
    tick();
    put(32'h344, 64'hAAAAAAAA_00000000, 8'hF0);
    tick();
    bus.v_wb_store = 0;
`ifdef SB_COALESCE_EN
    chk("co_count", bus.sb_count, 2);
`else
    chk("co_count", bus.sb_count, 3);
`endif
    bus.dc_wr_ack = 1;
    chk("co_e0_mask", bus.dc_wr_mask, 8'h0F);
    tick();
    chk("co_e1_addr", bus.dc_wr_addr, 32'h340);
`ifdef SB_COALESCE_EN
    chk("co_e1_mask", bus.dc_wr_mask, 8'hF1);
    chk("co_e1_data", bus.dc_wr_data, 64'hAAAAAAAA_11111111);
    tick();
`else
    chk("co_e1_mask", bus.dc_wr_mask, 8'h01);
    chk("co_e1_data", bus.dc_wr_data, 64'h11111111_11111111);
    tick();
    chk("co_e2_mask", bus.dc_wr_mask, 8'hF0);
    tick();
`endif
    chk("co_empty", bus.sb_empty, 1);
    // asynchronous reset mid-operation
    bus.dc_wr_ack = 0;
    for (int i = 0; i < 3; i++) begin
      put(32'h600 + 32'(8*i), 64'(i), 8'hFF);
      tick();
    end
    bus.v_wb_store = 0;
    chk("mid_count_pre", bus.sb_count, 3);
    CLR = 1;
    #1;
    chk("mid_count", bus.sb_count, 0);
    chk("mid_empty", bus.sb_empty, 1);
    chk("mid_req", bus.dc_wr_req, 0);
    tick();
    CLR = 0;
    tick();
    bus.dc_wr_ack = 1;
    put(32'h500, 64'h55, 8'h3C);
    tick();
    bus.v_wb_store = 0;
    chk("post_rst_req", bus.dc_wr_req, 1);
    chk("post_rst_addr", bus.dc_wr_addr, 32'h500);
    chk("post_rst_mask", bus.dc_wr_mask, 8'h3C);
    tick();
    chk("post_rst_empty", bus.sb_empty, 1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
